// File: rtl/video_fetch_pkg.sv
// video_fetch_pkg: shared types and constants for the video fetch block.
//   fetch_state_t : memory fetch sequencer states
//   mem_sel_t     : memory port target (video RAM / character ROM)
//   rom_addr()    : character ROM address {charset, code[6:0], row[2:0]}
package video_fetch_pkg;

   localparam int unsigned CELL_DOTS  = 16;
   localparam int unsigned GLYPH_ROWS = 8;
   localparam int unsigned CTR_W      = $clog2(CELL_DOTS);
   localparam int unsigned MEM_AW     = 11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_SCR_A = 3'd1,
      RD_SCR_B = 3'd2,
      RD_ROM_A = 3'd3,
      RD_ROM_B = 3'd4
   } fetch_state_t;

   typedef enum logic {
      MEM_SEL_VRAM = 1'b0,
      MEM_SEL_CROM = 1'b1
   } mem_sel_t;

   // Character ROM address for one glyph row.
   function automatic logic [MEM_AW-1:0] rom_addr(input logic       charset,
                                                  input logic [6:0] code,
                                                  input logic [2:0] row);
      return {charset, code, row};
   endfunction

endpackage

// File: rtl/video_pixel_double.sv
// video_pixel_double: widens one 8-dot glyph row to 16 dots by repeating
// every bit, MSB first (0xA5 -> 0xCC33). Purely combinational.
//   glyph    in  8   glyph row, MSB is the first dot
//   pixels_c out 16  doubled row
module video_pixel_double (
   input  logic [7:0]  glyph,
   output logic [15:0] pixels_c
);

   always_comb begin
      pixels_c = '0;
      for (int i = 0; i < 8; i++) begin
         pixels_c[2*i]   = glyph[i];
         pixels_c[2*i+1] = glyph[i];
      end
   end

endmodule

// File: rtl/video_fetch.sv
// video_fetch: per 16-dot cell, reads screen codes from video RAM and glyph
// rows from character ROM, then hands a 16-bit pixel word, reverse bits and
// display enable to the dot generator on the cell boundary.
// Optional feature macro: VIDEO_FETCH_COL80_EN (two chars per cell, col80_i
// port). Without it the block is fixed 40-col with one doubled char per cell.
// Ports:
//   sys_clock_i   in   1        system clock
//   sys_reset_i   in   1        synchronous active-high reset
//   pixel_clk_en  in   1        dot enable
//   ma_i          in   VRAM_AW  character address for the next cell
//   ra_i          in   5        raster row within the character
//   display_en_i  in   1        display enable for the next cell
//   charset_i     in   1        character set select
//   col80_i       in   1        80-col mode (macro builds only)
//   mem_req_o     out  1        memory read request
//   mem_sel_o     out  1        0 = video RAM, 1 = character ROM
//   mem_addr_o    out  11       read address
//   mem_ack_i     in   1        acknowledge, data valid same cycle
//   mem_data_i    in   8        read data
//   video_latch_o out  1        dot generator load strobe
//   pixels_o      out  16       [15:8] left char, [7:0] right char
//   reverse_o     out  2        [1] left reverse, [0] right reverse
//   display_en_o  out  1        display enable aligned with pixels_o
//   underrun_o    out  1        sticky: fetch incomplete at a boundary
module video_fetch
   import video_fetch_pkg::*;
#(
   parameter int unsigned VRAM_AW = 11,
   parameter int unsigned CROM_AW = 11
) (
   input  logic               sys_clock_i,
   input  logic               sys_reset_i,
   input  logic               pixel_clk_en,
   input  logic [VRAM_AW-1:0] ma_i,
   input  logic [4:0]         ra_i,
   input  logic               display_en_i,
   input  logic               charset_i,
`ifdef VIDEO_FETCH_COL80_EN
   input  logic               col80_i,
`endif
   output logic               mem_req_o,
   output logic               mem_sel_o,
   output logic [MEM_AW-1:0]  mem_addr_o,
   input  logic               mem_ack_i,
   input  logic [7:0]         mem_data_i,
   output logic               video_latch_o,
   output logic [15:0]        pixels_o,
   output logic [1:0]         reverse_o,
   output logic               display_en_o,
   output logic               underrun_o
);

   fetch_state_t     state;
   logic [CTR_W-1:0] cell_ctr;

   // Fetch registers, sampled at cell start.
   logic [4:0]       f_ra;
   logic             f_de;
   logic             f_charset;

   // Results of the fetch in progress / last completed fetch.
   logic             rev_a;
   logic [7:0]       glyph_a;

`ifdef VIDEO_FETCH_COL80_EN
   logic [VRAM_AW-1:0] f_ma;
   logic               f_col80;
   logic [6:0]         code_a_lo;
   logic [6:0]         code_b_lo;
   logic               rev_b;
   logic [7:0]         glyph_b;
   logic [VRAM_AW-1:0] ma_next_c;
`endif

   logic             cell_start_c;
   logic             row_blank_c;
   logic [15:0]      doubled_c;
   logic [15:0]      fetch_pixels_c;
   logic [1:0]       fetch_reverse_c;

   assign cell_start_c = pixel_clk_en && (cell_ctr == CTR_W'(CELL_DOTS - 1));
   // Rows past the glyph height have no ROM data; only reverse shows.
   assign row_blank_c  = (f_ra >= 5'(GLYPH_ROWS));

`ifdef VIDEO_FETCH_COL80_EN
   assign ma_next_c = f_ma + VRAM_AW'(1);
`endif

   video_pixel_double u_pixel_double (
      .glyph    (glyph_a),
      .pixels_c (doubled_c)
   );

   // Pixel word and reverse bits assembled from the completed fetch.
   always_comb begin
      fetch_pixels_c  = doubled_c;
      fetch_reverse_c = {2{rev_a}};
`ifdef VIDEO_FETCH_COL80_EN
      if (f_col80) begin
         fetch_pixels_c  = {glyph_a, glyph_b};
         fetch_reverse_c = {rev_a, rev_b};
      end
`endif
   end

   // Cell counter, output holding registers and fetch sequencer.
   always_ff @(posedge sys_clock_i) begin
      if (sys_reset_i) begin
         state         <= IDLE;
         cell_ctr      <= '0;
         f_ra          <= '0;
         f_de          <= 1'b0;
         f_charset     <= 1'b0;
         rev_a         <= 1'b0;
         glyph_a       <= '0;
         mem_req_o     <= 1'b0;
         mem_sel_o     <= 1'b0;
         mem_addr_o    <= '0;
         video_latch_o <= 1'b0;
         pixels_o      <= '0;
         reverse_o     <= '0;
         display_en_o  <= 1'b0;
         underrun_o    <= 1'b0;
`ifdef VIDEO_FETCH_COL80_EN
         f_ma          <= '0;
         f_col80       <= 1'b0;
         code_a_lo     <= '0;
         code_b_lo     <= '0;
         rev_b         <= 1'b0;
         glyph_b       <= '0;
`endif
      end else begin
         if (pixel_clk_en) begin
            cell_ctr      <= cell_ctr + CTR_W'(1);
            // Registered copy of (cell_ctr == 15).
            video_latch_o <= (cell_ctr == CTR_W'(CELL_DOTS - 2));
         end

         if (cell_start_c) begin
            // A fetch still running here is late: blank it and restart.
            if (state != IDLE) begin
               underrun_o <= 1'b1;
               pixels_o   <= '0;
               reverse_o  <= '0;
            end else begin
               pixels_o   <= fetch_pixels_c;
               reverse_o  <= fetch_reverse_c;
            end
            display_en_o <= f_de;
            f_ra         <= ra_i;
            f_de         <= display_en_i;
            f_charset    <= charset_i;
`ifdef VIDEO_FETCH_COL80_EN
            f_ma         <= ma_i;
            f_col80      <= col80_i;
`endif
            state        <= RD_SCR_A;
            mem_req_o    <= 1'b1;
            mem_sel_o    <= MEM_SEL_VRAM;
            mem_addr_o   <= MEM_AW'(ma_i);
         end else if (mem_ack_i) begin
            case (state)
               RD_SCR_A: begin
                  rev_a <= mem_data_i[7];
`ifdef VIDEO_FETCH_COL80_EN
                  if (f_col80) begin
                     code_a_lo  <= mem_data_i[6:0];
                     state      <= RD_SCR_B;
                     mem_addr_o <= MEM_AW'(ma_next_c);
                  end else
`endif
                  if (row_blank_c) begin
                     glyph_a   <= '0;
                     state     <= IDLE;
                     mem_req_o <= 1'b0;
                  end else begin
                     state      <= RD_ROM_A;
                     mem_sel_o  <= MEM_SEL_CROM;
                     mem_addr_o <= MEM_AW'(CROM_AW'(
                        rom_addr(f_charset, mem_data_i[6:0], f_ra[2:0])));
                  end
               end
`ifdef VIDEO_FETCH_COL80_EN
               RD_SCR_B: begin
                  rev_b     <= mem_data_i[7];
                  code_b_lo <= mem_data_i[6:0];
                  if (row_blank_c) begin
                     glyph_a   <= '0;
                     glyph_b   <= '0;
                     state     <= IDLE;
                     mem_req_o <= 1'b0;
                  end else begin
                     state      <= RD_ROM_A;
                     mem_sel_o  <= MEM_SEL_CROM;
                     mem_addr_o <= MEM_AW'(CROM_AW'(
                        rom_addr(f_charset, code_a_lo, f_ra[2:0])));
                  end
               end
               RD_ROM_B: begin
                  glyph_b   <= mem_data_i;
                  state     <= IDLE;
                  mem_req_o <= 1'b0;
               end
`endif
               RD_ROM_A: begin
                  glyph_a <= mem_data_i;
`ifdef VIDEO_FETCH_COL80_EN
                  if (f_col80) begin
                     state      <= RD_ROM_B;
                     mem_addr_o <= MEM_AW'(CROM_AW'(
                        rom_addr(f_charset, code_b_lo, f_ra[2:0])));
                  end else
`endif
                  begin
                     state     <= IDLE;
                     mem_req_o <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
